tx_symbol_serializer: RTL and testbench



---
 rtl/tx_symbol_serializer_pkg.sv | 21 ++
 rtl/tx_symbol_serializer_ones_count10.sv | 22 ++
 rtl/tx_symbol_serializer.sv | 136 +++++++++++++
 tb/tb_tx_symbol_serializer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/tx_symbol_serializer_pkg.sv
//------------------------------------------------------------------------------
// Module   : tx_symbol_serializer_pkg
// Purpose  : Shared constants and state encoding for the 8b/10b TX serializer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package tx_symbol_serializer_pkg;

    localparam int         SYMBOL_SIZE = 10;
    localparam logic [9:0] K285_RDN    = 10'h17C;
    localparam logic [9:0] K285_RDP    = 10'h283;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/tx_symbol_serializer_ones_count10.sv
//------------------------------------------------------------------------------
// Module   : ones_count10
// Purpose  : Combinational popcount of a 10-bit symbol (result 0..10).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ones_count10 (
    input  logic [9:0] i_data,
    output logic [3:0] o_count
);

    always_comb begin
        o_count = 4'd0;
        for (int i = 0; i < 10; i++) begin
            o_count = o_count + {3'd0, i_data[i]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/tx_symbol_serializer.sv
//------------------------------------------------------------------------------
// Module   : tx_symbol_serializer
// Purpose  : Serializes 10-bit symbols LSB first, inserting K28.5 commas when
//            no data is offered. Optional disparity check: TX_DISP_CHECK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tx_symbol_serializer
    import tx_symbol_serializer_pkg::*;
#(
    parameter int SIZE = 10
) (
    input  logic            TRANSCLK,
    input  logic            RESET,
    input  logic [SIZE-1:0] data_in,
    input  logic            data_valid,
    output logic            data_ready,
    input  logic            TXIDLE_REQ,
    output logic            data_out,
    output logic            TXIDLE,
    output logic            SYMBOL_CLK,
    output logic            DISP_ERR
);

    generate
        if (SIZE != SYMBOL_SIZE) begin : g_size_check
            $error("tx_symbol_serializer: SIZE must be 10");
        end
    endgenerate

    tx_state_e  state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [9:0] shreg_q, shreg_d;
    logic       rd_q, rd_d;          // 1 = positive running disparity
    logic       data_out_q, data_out_d;
    logic       txidle_q, txidle_d;
    logic       symclk_q, symclk_d;

    logic       load_slot;
    logic [9:0] sym_sel;
    logic [3:0] sym_ones;

    assign load_slot  = !TXIDLE_REQ && ((state_q == ST_IDLE) || (bit_cnt_q == 4'd9));
    assign data_ready = load_slot;
    assign sym_sel    = data_valid ? data_in : (rd_q ? K285_RDP : K285_RDN);

    ones_count10 u_ones (
        .i_data  (sym_sel),
        .o_count (sym_ones)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        rd_d       = rd_q;
        data_out_d = data_out_q;
        txidle_d   = txidle_q;
        symclk_d   = 1'b0;

        if (load_slot) begin
            // Bit 0 goes straight to the output flop; the rest waits in shreg.
            state_d    = ST_RUN;
            bit_cnt_d  = 4'd0;
            shreg_d    = {1'b0, sym_sel[9:1]};
            data_out_d = sym_sel[0];
            txidle_d   = 1'b0;
            symclk_d   = 1'b1;
            if (sym_ones > 4'd5) begin
                rd_d = 1'b1;
            end else if (sym_ones < 4'd5) begin
                rd_d = 1'b0;
            end
        end else if (state_q == ST_IDLE || bit_cnt_q == 4'd9) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = 4'd0;
            data_out_d = 1'b0;
            txidle_d   = 1'b1;
        end else begin
            bit_cnt_d  = bit_cnt_q + 4'd1;
            shreg_d    = {1'b0, shreg_q[9:1]};
            data_out_d = shreg_q[0];
        end
    end

`ifdef TX_DISP_CHECK_EN
    logic disp_err_q, disp_err_d;

    always_comb begin
        disp_err_d = 1'b0;
        if (load_slot && data_valid) begin
            disp_err_d = (sym_ones < 4'd4) || (sym_ones > 4'd6) ||
                         ((sym_ones == 4'd6) && rd_q) ||
                         ((sym_ones == 4'd4) && !rd_q);
        end
    end

    assign DISP_ERR = disp_err_q;
`else
    assign DISP_ERR = 1'b0;
`endif

    always_ff @(posedge TRANSCLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shreg_q    <= 10'd0;
            rd_q       <= 1'b0;
            data_out_q <= 1'b0;
            txidle_q   <= 1'b1;
            symclk_q   <= 1'b0;
`ifdef TX_DISP_CHECK_EN
            disp_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            rd_q       <= rd_d;
            data_out_q <= data_out_d;
            txidle_q   <= txidle_d;
            symclk_q   <= symclk_d;
`ifdef TX_DISP_CHECK_EN
            disp_err_q <= disp_err_d;
`endif
        end
    end

    assign data_out   = data_out_q;
    assign TXIDLE     = txidle_q;
    assign SYMBOL_CLK = symclk_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_symbol_serializer.sv
//------------------------------------------------------------------------------
// Module   : tb_tx_symbol_serializer
// Purpose  : Directed self-checking bench for tx_symbol_serializer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tx_symbol_serializer;

    logic       TRANSCLK = 1'b0;
    logic       RESET    = 1'b1;
    logic [9:0] data_in  = 10'd0;
    logic       data_valid = 1'b0;
    logic       TXIDLE_REQ = 1'b0;
    logic       data_ready, data_out, TXIDLE, SYMBOL_CLK, DISP_ERR;

    int vectors    = 0;
    int miscompares = 0;

`ifdef TX_DISP_CHECK_EN
    localparam logic C_DE_EXP = 1'b1;
`else
    localparam logic C_DE_EXP = 1'b0;
`endif

    tx_symbol_serializer #(.SIZE(10)) dut (
        .TRANSCLK   (TRANSCLK),
        .RESET      (RESET),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .TXIDLE_REQ (TXIDLE_REQ),
        .data_out   (data_out),
        .TXIDLE     (TXIDLE),
        .SYMBOL_CLK (SYMBOL_CLK),
        .DISP_ERR   (DISP_ERR)
    );

    always #5 TRANSCLK = ~TRANSCLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic advance();
        @(posedge TRANSCLK);
        #1;
    endtask

    // Entered in the cycle showing bit 0; leaves in the cycle showing bit 9.
    task automatic check_symbol(input string tag, input logic [9:0] sym,
                                input logic de0, input int req_at);
        for (int n = 0; n < 10; n++) begin
            if (n == req_at) TXIDLE_REQ = 1'b1;
            chk({tag, ".bit"}, data_out, sym[n]);
            chk({tag, ".symclk"}, SYMBOL_CLK, (n == 0));
            chk({tag, ".txidle"}, TXIDLE, 1'b0);
            chk({tag, ".disperr"}, DISP_ERR, (n == 0) ? de0 : 1'b0);
            if (n < 9) advance();
        end
    endtask

    // Present inputs in the bit-9 / idle cycle and check the handshake.
    task automatic offer(input string tag, input logic v, input logic [9:0] d,
                         input logic req, input logic exp_ready);
        data_valid = v;
        data_in    = d;
        TXIDLE_REQ = req;
        #1;
        chk({tag, ".ready"}, data_ready, exp_ready);
        advance();
    endtask

    initial begin
        repeat (3) @(posedge TRANSCLK);
        #1;
        chk("rst.txidle", TXIDLE, 1'b1);
        chk("rst.data_out", data_out, 1'b0);
        chk("rst.symclk", SYMBOL_CLK, 1'b0);
        chk("rst.disperr", DISP_ERR, 1'b0);
        @(negedge TRANSCLK);
        RESET = 1'b0;
        advance();

        // Comma stream alternates disparity.
        check_symbol("comma0", 10'h17C, 1'b0, -1);
        offer("comma1", 1'b0, 10'h000, 1'b0, 1'b1);
        check_symbol("comma1", 10'h283, 1'b0, -1);

        // Back-to-back balanced data leaves RD negative.
        offer("d2aa", 1'b1, 10'h2AA, 1'b0, 1'b1);
        check_symbol("d2aa", 10'h2AA, 1'b0, -1);
        offer("d155", 1'b1, 10'h155, 1'b0, 1'b1);
        check_symbol("d155", 10'h155, 1'b0, -1);
        offer("comma2", 1'b0, 10'h000, 1'b0, 1'b1);
        check_symbol("comma2", 10'h17C, 1'b0, 4);

        // Idle request wins over offered data at the boundary.
        offer("idle_vs_data", 1'b1, 10'h0F8, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("idle.txidle", TXIDLE, 1'b1);
            chk("idle.data_out", data_out, 1'b0);
            chk("idle.symclk", SYMBOL_CLK, 1'b0);
            #1;
            chk("idle.ready", data_ready, 1'b0);
            advance();
        end
        offer("idle_exit", 1'b1, 10'h0F8, 1'b0, 1'b1);
        check_symbol("d0f8", 10'h0F8, 1'b0, -1);

        // RD held positive through IDLE.
        offer("comma3", 1'b0, 10'h000, 1'b0, 1'b1);
        check_symbol("comma3", 10'h283, 1'b0, -1);

        // Eight ones with RD negative.
        offer("d0ff", 1'b1, 10'h0FF, 1'b0, 1'b1);
        check_symbol("d0ff", 10'h0FF, C_DE_EXP, -1);
        offer("comma4", 1'b0, 10'h000, 1'b0, 1'b1);
        check_symbol("comma4", 10'h283, 1'b0, -1);

        // Reset at bit 4 of the next comma.
        offer("comma5", 1'b0, 10'h000, 1'b0, 1'b1);
        repeat (4) advance();
        chk("mid.bit4", data_out, 1'b1);
        chk("mid.txidle", TXIDLE, 1'b0);
        #2;
        RESET = 1'b1;
        #1;
        chk("mid_rst.data_out", data_out, 1'b0);
        chk("mid_rst.txidle", TXIDLE, 1'b1);
        chk("mid_rst.symclk", SYMBOL_CLK, 1'b0);
        @(negedge TRANSCLK);
        RESET = 1'b0;
        advance();
        check_symbol("post_rst", 10'h17C, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
